// File: rtl/pool_window_feeder_if.sv
// Handshake bundle between the window feeder, its feature-map buffer and the pooling unit.
// master = feeder side, slave = buffer/pooling-unit side.
interface pool_window_feeder_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 16
);
  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic                  pool_start;
  logic                  pool_valid;
  logic [DATA_WIDTH-1:0] pool_data;
  logic                  pool_busy;
  logic                  pool_done;

  modport master (
    output mem_rd_en, mem_addr, pool_start, pool_valid, pool_data,
    input  mem_rd_data, pool_busy, pool_done
  );

  modport slave (
    input  mem_rd_en, mem_addr, pool_start, pool_valid, pool_data,
    output mem_rd_data, pool_busy, pool_done
  );
endinterface

// File: rtl/pool_window_feeder.sv
// Walks a feature-map channel in raster order of pooling windows, reading each KxK window
// row-major from the buffer and streaming it to the pooling unit, one window per handshake.
module pool_window_feeder #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            kernel_size,
  input  logic                  stride_sel,
  input  logic [7:0]            in_width,
  input  logic [7:0]            in_height,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_error,
  pool_window_feeder_if.master  bus
);

  typedef enum logic [2:0] {
    StIdle, StArm, StWaitBusy, StStream, StWaitDone, StFinish
  } state_e;

  state_e                state_q, state_d;
  logic                  k3_q, k3_d;
  logic                  s2_q, s2_d;
  logic [7:0]            width_q, width_d;
  logic [7:0]            out_w_q, out_w_d;
  logic [7:0]            out_h_q, out_h_d;
  logic [7:0]            ox_q, ox_d;
  logic [7:0]            oy_q, oy_d;
  logic [1:0]            kx_q, kx_d;
  logic [1:0]            ky_q, ky_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic                  cfg_err_q, cfg_err_d;
  logic                  pool_valid_q;

  // Decode of the live configuration inputs, only used in the accept cycle
  logic [7:0] k_in, span_w, span_h, new_out_w, new_out_h;
  logic       too_small;

  assign k_in      = (kernel_size == 2'b01) ? 8'd3 : 8'd2;
  assign too_small = (in_width < k_in) || (in_height < k_in);
  assign span_w    = in_width - k_in;
  assign span_h    = in_height - k_in;
  assign new_out_w = (stride_sel ? (span_w >> 1) : span_w) + 8'd1;
  assign new_out_h = (stride_sel ? (span_h >> 1) : span_h) + 8'd1;

  logic [1:0] k_last;
  assign k_last = k3_q ? 2'd2 : 2'd1;

  // Element address; ADDR_WIDTH-wide arithmetic gives the modulo wrap for free
  logic [8:0]            row, col;
  logic [ADDR_WIDTH-1:0] elem_addr;

  assign row = (s2_q ? {oy_q, 1'b0} : {1'b0, oy_q}) + {7'd0, ky_q};
  assign col = (s2_q ? {ox_q, 1'b0} : {1'b0, ox_q}) + {7'd0, kx_q};
  assign elem_addr = base_q + ADDR_WIDTH'(row) * ADDR_WIDTH'(width_q) + ADDR_WIDTH'(col);

  always_comb begin
    state_d        = state_q;
    k3_d           = k3_q;
    s2_d           = s2_q;
    width_d        = width_q;
    out_w_d        = out_w_q;
    out_h_d        = out_h_q;
    ox_d           = ox_q;
    oy_d           = oy_q;
    kx_d           = kx_q;
    ky_d           = ky_q;
    base_d         = base_q;
    cfg_err_d      = cfg_err_q;
    bus.pool_start = 1'b0;
    bus.mem_rd_en  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          k3_d      = (kernel_size == 2'b01);
          s2_d      = stride_sel;
          width_d   = in_width;
          base_d    = base_addr;
          out_w_d   = new_out_w;
          out_h_d   = new_out_h;
          ox_d      = 8'd0;
          oy_d      = 8'd0;
          kx_d      = 2'd0;
          ky_d      = 2'd0;
          cfg_err_d = too_small;
          state_d   = too_small ? StFinish : StArm;
        end
      end
      StArm: begin
        if (!bus.pool_busy) begin
          bus.pool_start = 1'b1;
          state_d        = StWaitBusy;
        end
      end
      StWaitBusy: begin
        if (bus.pool_busy) state_d = StStream;
      end
      StStream: begin
        bus.mem_rd_en = 1'b1;
        if (kx_q == k_last) begin
          kx_d = 2'd0;
          if (ky_q == k_last) begin
            ky_d    = 2'd0;
            state_d = StWaitDone;
          end else begin
            ky_d = ky_q + 2'd1;
          end
        end else begin
          kx_d = kx_q + 2'd1;
        end
      end
      StWaitDone: begin
        if (bus.pool_done) begin
          if (ox_q == out_w_q - 8'd1) begin
            ox_d = 8'd0;
            if (oy_q == out_h_q - 8'd1) begin
              state_d = StFinish;
            end else begin
              oy_d    = oy_q + 8'd1;
              state_d = StArm;
            end
          end else begin
            ox_d    = ox_q + 8'd1;
            state_d = StArm;
          end
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      k3_q         <= 1'b0;
      s2_q         <= 1'b0;
      width_q      <= 8'd0;
      out_w_q      <= 8'd0;
      out_h_q      <= 8'd0;
      ox_q         <= 8'd0;
      oy_q         <= 8'd0;
      kx_q         <= 2'd0;
      ky_q         <= 2'd0;
      base_q       <= '0;
      cfg_err_q    <= 1'b0;
      pool_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      k3_q         <= k3_d;
      s2_q         <= s2_d;
      width_q      <= width_d;
      out_w_q      <= out_w_d;
      out_h_q      <= out_h_d;
      ox_q         <= ox_d;
      oy_q         <= oy_d;
      kx_q         <= kx_d;
      ky_q         <= ky_d;
      base_q       <= base_d;
      cfg_err_q    <= cfg_err_d;
      pool_valid_q <= bus.mem_rd_en;
    end
  end

  logic [DATA_WIDTH-1:0] rd_data;
  assign rd_data = bus.mem_rd_data;

  assign busy           = (state_q != StIdle);
  assign done           = (state_q == StFinish);
  assign cfg_error      = done && cfg_err_q;
  assign bus.mem_addr   = (state_q == StStream) ? elem_addr : '0;
  assign bus.pool_valid = pool_valid_q;
  // Gate with the delayed valid so stale buffer data never leaks out, e.g. after reset
  assign bus.pool_data  = pool_valid_q ? rd_data : '0;

endmodule

// File: tb/tb_pool_window_feeder.sv
// Directed bench for pool_window_feeder: buffer model returns addr[7:0], pooling-unit model
// computes a max per window with a programmable done hold-off.
module tb_pool_window_feeder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  kernel_size;
  logic        stride_sel;
  logic [7:0]  in_width;
  logic [7:0]  in_height;
  logic [15:0] base_addr;
  logic        busy;
  logic        done;
  logic        cfg_error;

  pool_window_feeder_if #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) bus ();

  pool_window_feeder #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .kernel_size (kernel_size),
    .stride_sel  (stride_sel),
    .in_width    (in_width),
    .in_height   (in_height),
    .base_addr   (base_addr),
    .busy        (busy),
    .done        (done),
    .cfg_error   (cfg_error),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Buffer model: one-cycle read latency, data = low address byte
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= bus.mem_addr[7:0];
  end

  // Pooling-unit model (max mode)
  logic       pm_busy, pm_done, pm_active, inj_done;
  int         pm_cnt, pm_wait, pm_kk, holdoff;
  logic [7:0] pm_max;
  logic [7:0] rq[$];

  assign bus.pool_busy = pm_busy;
  assign bus.pool_done = pm_done | inj_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pm_busy <= 1'b0; pm_done <= 1'b0; pm_active <= 1'b0;
      pm_cnt  <= 0;    pm_wait <= 0;    pm_max    <= 8'd0;
    end else begin
      pm_done <= 1'b0;
      if (bus.pool_start && !pm_active) begin
        pm_active <= 1'b1; pm_busy <= 1'b1;
        pm_cnt    <= 0;    pm_wait <= 0;   pm_max <= 8'd0;
      end else if (pm_active) begin
        if (bus.pool_valid) begin
          pm_cnt <= pm_cnt + 1;
          if (bus.pool_data > pm_max) pm_max <= bus.pool_data;
        end else if (pm_cnt == pm_kk) begin
          if (pm_wait == holdoff) begin
            pm_done <= 1'b1; pm_busy <= 1'b0; pm_active <= 1'b0;
            rq.push_back(pm_max);
          end else begin
            pm_wait <= pm_wait + 1;
          end
        end
      end
    end
  end

  // Monitor, sampled on the falling edge
  logic [7:0]  vq[$];
  logic [15:0] aq[$];
  int          n_start, n_done, done_cyc, start_cyc;
  logic        done_err;

  always @(negedge clk) begin
    if (bus.pool_valid) vq.push_back(bus.pool_data);
    if (bus.mem_rd_en) aq.push_back(bus.mem_addr);
    if (bus.pool_start) n_start++;
    if (done) begin
      n_done++;
      done_err = cfg_error;
      done_cyc = cyc;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] vq_at(input int i);
    return (i < vq.size()) ? 32'(vq[i]) : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] aq_at(input int i);
    return (i < aq.size()) ? 32'(aq[i]) : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] rq_at(input int i);
    return (i < rq.size()) ? 32'(rq[i]) : 32'hDEAD_BEEF;
  endfunction

  task automatic check_quiet(input string p);
    check({p, "_busy"},       32'(busy), 0);
    check({p, "_done"},       32'(done), 0);
    check({p, "_cfg_error"},  32'(cfg_error), 0);
    check({p, "_mem_rd_en"},  32'(bus.mem_rd_en), 0);
    check({p, "_pool_start"}, 32'(bus.pool_start), 0);
    check({p, "_pool_valid"}, 32'(bus.pool_valid), 0);
    check({p, "_mem_addr"},   32'(bus.mem_addr), 0);
    check({p, "_pool_data"},  32'(bus.pool_data), 0);
  endtask

  task automatic launch(input logic [1:0] ks, input logic ss, input logic [7:0] w,
                        input logic [7:0] h, input logic [15:0] base, input int kk,
                        input int ho);
    vq.delete(); aq.delete(); rq.delete();
    n_start = 0; n_done = 0; done_err = 1'b0;
    pm_kk = kk; holdoff = ho;
    @(negedge clk);
    kernel_size = ks; stride_sel = ss; in_width = w; in_height = h; base_addr = base;
    start = 1'b1; start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    #1;
  endtask

  task automatic wait_done(input string p, input int budget);
    int c = 0;
    while (n_done == 0 && c < budget) begin
      @(negedge clk); #1; c++;
    end
    check({p, "_done_seen"}, 32'(n_done != 0), 1);
    repeat (3) @(negedge clk);
    #1;
    check({p, "_done_count"}, 32'(n_done), 1);
    check({p, "_idle_after"}, 32'(busy), 0);
  endtask

  int exp_a[16] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
  int exp_b_first[9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
  int exp_b_last[9]  = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
  int max_a[4] = '{5, 7, 13, 15};
  int max_b[4] = '{10, 11, 14, 15};
  int exp_e[8] = '{16'hFFFE, 16'hFFFF, 16'h0002, 16'h0003, 16'h0008, 16'h0009, 16'h000C, 16'h000D};
  int exp_f[4] = '{6, 7, 11, 12};

  task automatic check_stream_a(input string p);
    for (int i = 0; i < 16; i++) check($sformatf("%s_elem%0d", p, i), vq_at(i), 32'(exp_a[i]));
    for (int i = 0; i < 4; i++) check($sformatf("%s_max%0d", p, i), rq_at(i), 32'(max_a[i]));
    check({p, "_valid_count"}, 32'(vq.size()), 16);
    check({p, "_start_count"}, 32'(n_start), 4);
    check({p, "_cfg_error"}, 32'(done_err), 0);
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; kernel_size = 2'b00; stride_sel = 1'b0;
    in_width = 8'd0; in_height = 8'd0; base_addr = 16'd0;
    inj_done = 1'b0; holdoff = 0; pm_kk = 4;
    n_start = 0; n_done = 0; done_cyc = 0; start_cyc = 0; done_err = 1'b0;

    // Reset state
    #3 rst_n = 1'b0;
    #1 check_quiet("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("idle_busy", 32'(busy), 0);

    // 4x4, K=2, S=2
    launch(2'b00, 1'b1, 8'd4, 8'd4, 16'd0, 4, 0);
    check("a_busy_after_start", 32'(busy), 1);
    wait_done("a", 2000);
    check_stream_a("a");

    // 4x4, K=3, S=1
    launch(2'b01, 1'b0, 8'd4, 8'd4, 16'd0, 9, 0);
    wait_done("b", 2000);
    check("b_valid_count", 32'(vq.size()), 36);
    check("b_start_count", 32'(n_start), 4);
    for (int i = 0; i < 9; i++) check($sformatf("b_first%0d", i), vq_at(i), 32'(exp_b_first[i]));
    for (int i = 0; i < 9; i++) check($sformatf("b_last%0d", i), vq_at(27 + i), 32'(exp_b_last[i]));
    for (int i = 0; i < 4; i++) check($sformatf("b_max%0d", i), rq_at(i), 32'(max_b[i]));

    // Window does not fit: in_width=1, K=2
    launch(2'b00, 1'b0, 8'd1, 8'd4, 16'd0, 4, 0);
    repeat (2) @(negedge clk);
    #1;
    check("c_done_count", 32'(n_done), 1);
    check("c_cfg_error", 32'(done_err), 1);
    check("c_latency_ok", 32'((done_cyc - start_cyc) <= 2), 1);
    check("c_no_pool_start", 32'(n_start), 0);
    check("c_no_rd", 32'(aq.size()), 0);
    check("c_idle", 32'(busy), 0);

    // Slow pooling unit: 20-cycle done hold-off per window
    launch(2'b00, 1'b1, 8'd4, 8'd4, 16'd0, 4, 20);
    wait_done("d", 3000);
    check_stream_a("d");

    // Address wrap modulo 2^16
    launch(2'b00, 1'b1, 8'd4, 8'd4, 16'hFFFE, 4, 0);
    wait_done("e", 2000);
    for (int i = 0; i < 4; i++) check($sformatf("e_addr%0d", i), aq_at(i), 32'(exp_e[i]));
    for (int i = 0; i < 4; i++) check($sformatf("e_addr%0d", 12 + i), aq_at(12 + i), 32'(exp_e[4 + i]));

    // Non-square 5x3, K=2, S=1 -> 4x2 windows
    launch(2'b00, 1'b0, 8'd5, 8'd3, 16'd0, 4, 0);
    wait_done("f", 2000);
    check("f_start_count", 32'(n_start), 8);
    check("f_valid_count", 32'(vq.size()), 32);
    for (int i = 0; i < 4; i++) check($sformatf("f_addr%0d", 20 + i), aq_at(20 + i), 32'(exp_f[i]));

    // Start, config change and stray pool_done while streaming are all ignored
    launch(2'b00, 1'b1, 8'd4, 8'd4, 16'd0, 4, 0);
    begin
      int c = 0;
      while (aq.size() == 0 && c < 100) begin @(negedge clk); #1; c++; end
    end
    check("g_in_stream", 32'(bus.mem_rd_en), 1);
    @(negedge clk);
    base_addr = 16'd100; kernel_size = 2'b01; stride_sel = 1'b0; start = 1'b1; inj_done = 1'b1;
    @(negedge clk);
    start = 1'b0; inj_done = 1'b0;
    #1;
    wait_done("g", 2000);
    check_stream_a("g");

    // Reset after the 2nd element of window 1, then replay from window 0
    launch(2'b00, 1'b1, 8'd4, 8'd4, 16'd0, 4, 0);
    begin
      int c = 0;
      while (vq.size() < 6 && c < 200) begin @(negedge clk); #1; c++; end
    end
    check("h_reached_elem6", 32'(vq.size()), 6);
    #1 rst_n = 1'b0;
    #1 check_quiet("h_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    vq.delete();
    repeat (5) @(negedge clk);
    #1;
    check("h_no_valid_after_release", 32'(vq.size()), 0);
    launch(2'b00, 1'b1, 8'd4, 8'd4, 16'd0, 4, 0);
    wait_done("h", 2000);
    check_stream_a("h");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
